// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Per-PC 2-bit saturating-counter branch history table (BHT). Trained by the
// commit stage with resolved conditional-branch outcomes; answers fetch
// queries with a registered taken/not-taken direction one cycle later. The
// fetch unit computes targets; this block supplies only the direction.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// Predicted taken iff the counter MSB is set. No tags: PCs with equal
// pc[IDX_W+1:2] share a counter.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_in           asynchronous active-low reset
//   rdy_in           global ready; low freezes all state and outputs
//   commit_en_in     commit reports a resolved conditional branch
//   commit_pc_in     PC of the committed branch
//   commit_bpres_in  actual outcome, 1 = taken
//   query_en_in      fetch requests a prediction
//   query_pc_in      PC of the fetched branch
//   clear_in         misprediction flush; squashes an in-flight query
//   bp_valid_out     prediction valid (one cycle after the query)
//   bp_taken_out     predicted direction
//   bp_pc_out        PC the prediction belongs to
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              commit_en_in,
  input  logic [ADDR_W-1:0] commit_pc_in,
  input  logic              commit_bpres_in,
  input  logic              query_en_in,
  input  logic [ADDR_W-1:0] query_pc_in,
  input  logic              clear_in,
  output logic              bp_valid_out,
  output logic              bp_taken_out,
  output logic [ADDR_W-1:0] bp_pc_out
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef logic [1:0] ctr_t;
  localparam ctr_t WEAK_NT = 2'b01;

  // Saturating step: taken moves toward 11, not-taken toward 00.
  function automatic ctr_t sat(input ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  ctr_t             bht [ENTRIES];
  logic             pend_valid;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_bpres;

  logic [IDX_W-1:0] commit_idx;
  logic [IDX_W-1:0] query_idx;
  ctr_t             eff_ctr;

  assign commit_idx = commit_pc_in[IDX_W+1:2];
  assign query_idx  = query_pc_in[IDX_W+1:2];

  // Only the index bits of the commit PC take part; the rest are don't-care.
  logic unused_commit_bits;
  assign unused_commit_bits = ^{commit_pc_in[ADDR_W-1:IDX_W+2], commit_pc_in[1:0]};

  // The pending update has not reached the table yet, so a query to the same
  // index forwards it. This makes every commit from an earlier cycle visible.
  always_comb begin
    // NOTE: a default assignment first on every path keeps always_comb free of
    // inferred latches.
    eff_ctr = bht[query_idx];
    if (pend_valid && (pend_idx == query_idx)) begin
      eff_ctr = sat(bht[query_idx], pend_bpres);
    end
  end

  // Stage 1 of the update pipeline: capture the committed outcome.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_bpres <= 1'b0;
    end else if (rdy_in) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      pend_valid <= commit_en_in;
      if (commit_en_in) begin
        pend_idx   <= commit_idx;
        pend_bpres <= commit_bpres_in;
      end
    end
  end

  // Stage 2: read-modify-write of the counter. Back-to-back updates to one
  // index accumulate because each write reads the value the previous edge
  // stored.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: the table is reset (every counter to weak-NT), so it is built
      // from resettable flops rather than an inferred RAM.
      for (int i = 0; i < ENTRIES; i++) bht[i] <= WEAK_NT;
    end else if (rdy_in && pend_valid) begin
      bht[pend_idx] <= sat(bht[pend_idx], pend_bpres);
    end
  end

  // Registered prediction. A clear drops a same-cycle query; direction and PC
  // hold when no new prediction is produced.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bp_valid_out <= 1'b0;
      bp_taken_out <= 1'b0;
      bp_pc_out    <= '0;
    end else if (rdy_in) begin
      if (query_en_in && !clear_in) begin
        bp_valid_out <= 1'b1;
        bp_taken_out <= eff_ctr[1];
        bp_pc_out    <= query_pc_in;
      end else begin
        bp_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed scenarios plus randomized traffic against a behavioural model: an
// array of integer counters updated with plain arithmetic the moment a commit
// is accepted. A query sees the model as it stood before the current cycle's
// commit.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int IDX_W   = 8;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 1 << IDX_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              commit_en_in;
  logic [ADDR_W-1:0] commit_pc_in;
  logic              commit_bpres_in;
  logic              query_en_in;
  logic [ADDR_W-1:0] query_pc_in;
  logic              clear_in;
  logic              bp_valid_out;
  logic              bp_taken_out;
  logic [ADDR_W-1:0] bp_pc_out;

  branch_predictor #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .commit_en_in   (commit_en_in),
    .commit_pc_in   (commit_pc_in),
    .commit_bpres_in(commit_bpres_in),
    .query_en_in    (query_en_in),
    .query_pc_in    (query_pc_in),
    .clear_in       (clear_in),
    .bp_valid_out   (bp_valid_out),
    .bp_taken_out   (bp_taken_out),
    .bp_pc_out      (bp_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int                mdl [ENTRIES];
  logic              exp_valid;
  logic              exp_taken;
  logic [ADDR_W-1:0] exp_pc;

  function automatic int idx_of(input logic [ADDR_W-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) mdl[i] = 1;
    exp_valid = 1'b0;
    exp_taken = 1'b0;
    exp_pc    = '0;
  endtask

  // Drive one cycle of inputs, advance the model, wait past the edge.
  task automatic step(input bit rdy, input bit ce, input logic [ADDR_W-1:0] cpc,
                      input bit cb, input bit qe, input logic [ADDR_W-1:0] qpc,
                      input bit clr);
    int ci;
    rdy_in          = rdy;
    commit_en_in    = ce;
    commit_pc_in    = cpc;
    commit_bpres_in = cb;
    query_en_in     = qe;
    query_pc_in     = qpc;
    clear_in        = clr;
    if (rdy) begin
      if (qe && !clr) begin
        exp_valid = 1'b1;
        exp_pc    = qpc;
        exp_taken = (mdl[idx_of(qpc)] >= 2);
      end else begin
        exp_valid = 1'b0;
      end
      if (ce) begin
        ci = idx_of(cpc);
        if (cb) mdl[ci] = (mdl[ci] == 3) ? 3 : mdl[ci] + 1;
        else    mdl[ci] = (mdl[ci] == 0) ? 0 : mdl[ci] - 1;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    step(1, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_commit(input logic [ADDR_W-1:0] pc, input bit b);
    step(1, 1, pc, b, 0, '0, 0);
  endtask

  task automatic do_query(input logic [ADDR_W-1:0] pc);
    step(1, 0, '0, 0, 1, pc, 0);
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    step(1, 0, '0, 0, 0, '0, 0);
    model_reset();
    n_checks++;
    if (bp_valid_out !== 1'b0 || bp_taken_out !== 1'b0 || bp_pc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b taken=%b pc=%h, want 0/0/0",
               bp_valid_out, bp_taken_out, bp_pc_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    do_query(32'h1000);
    n_checks++;
    if (bp_valid_out !== 1'b1 || bp_taken_out !== 1'b0 || bp_pc_out !== 32'h1000) begin
      n_fail++;
      $display("FAIL reset_first_query: got valid=%b taken=%b pc=%h, want 1/0/00001000",
               bp_valid_out, bp_taken_out, bp_pc_out);
    end
    idle();
    n_checks++;
    if (bp_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_drop: got valid=%b, want 0", bp_valid_out);
    end
  endtask

  task automatic test_training();
    bit outcome  [7] = '{1, 1, 0, 0, 0, 0, 1};
    bit want_tkn [7] = '{1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      do_commit(32'h1000, outcome[i]);
      idle();
      do_query(32'h1000);
      n_checks++;
      if (bp_valid_out !== 1'b1 || bp_taken_out !== want_tkn[i] || bp_taken_out !== exp_taken) begin
        n_fail++;
        $display("FAIL training_%0d: got valid=%b taken=%b, want 1/%b (model %b)",
                 i, bp_valid_out, bp_taken_out, want_tkn[i], exp_taken);
      end
    end
  endtask

  task automatic test_forwarding();
    // Counter for 0x1000 starts at 01.
    do_commit(32'h1000, 1);
    do_query(32'h1000);
    n_checks++;
    if (bp_taken_out !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_next_cycle: got taken=%b, want 1", bp_taken_out);
    end
    do_commit(32'h1000, 0);
    idle();
    step(1, 1, 32'h1000, 1, 1, 32'h1000, 0);
    n_checks++;
    if (bp_valid_out !== 1'b1 || bp_taken_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_same_cycle: got valid=%b taken=%b, want 1/0", bp_valid_out, bp_taken_out);
    end
    do_commit(32'h1000, 0);
    idle();
    do_commit(32'h1000, 1);
    do_commit(32'h1000, 1);
    idle();
    do_query(32'h1000);
    n_checks++;
    if (bp_taken_out !== 1'b1 || mdl[idx_of(32'h1000)] != 3) begin
      n_fail++;
      $display("FAIL fwd_back_to_back: got taken=%b, want 1 (model ctr %0d, want 3)",
               bp_taken_out, mdl[idx_of(32'h1000)]);
    end
    // A strongly-taken counter must survive one not-taken: proves both
    // back-to-back writes landed.
    do_commit(32'h1000, 0);
    idle();
    do_query(32'h1000);
    n_checks++;
    if (bp_taken_out !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_accumulate: got taken=%b, want 1", bp_taken_out);
    end
    do_commit(32'h1000, 0);
    idle();
  endtask

  task automatic test_aliasing();
    do_commit(32'h1000, 1);
    do_commit(32'h1000, 1);
    idle();
    do_query(32'h1400);
    n_checks++;
    if (bp_taken_out !== 1'b1 || bp_pc_out !== 32'h1400) begin
      n_fail++;
      $display("FAIL alias_shared: got taken=%b pc=%h, want 1/00001400", bp_taken_out, bp_pc_out);
    end
    do_query(32'h1004);
    n_checks++;
    if (bp_taken_out !== 1'b0 || bp_pc_out !== 32'h1004) begin
      n_fail++;
      $display("FAIL alias_isolated: got taken=%b pc=%h, want 0/00001004", bp_taken_out, bp_pc_out);
    end
    do_commit(32'h1000, 0);
    do_commit(32'h1000, 0);
    idle();
  endtask

  task automatic test_hold();
    do_query(32'h1000);
    step(0, 1, 32'h2000, 1, 1, 32'h3000, 0);
    n_checks++;
    if (bp_valid_out !== 1'b1 || bp_pc_out !== 32'h1000 || bp_taken_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_outputs: got valid=%b taken=%b pc=%h, want 1/0/00001000",
               bp_valid_out, bp_taken_out, bp_pc_out);
    end
    idle();
    do_query(32'h2000);
    n_checks++;
    if (bp_taken_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_commit_ignored: got taken=%b, want 0", bp_taken_out);
    end
    step(1, 0, '0, 0, 1, 32'h2000, 1);
    n_checks++;
    if (bp_valid_out !== 1'b0 || bp_pc_out !== 32'h2000) begin
      n_fail++;
      $display("FAIL clear_squash: got valid=%b pc=%h, want 0/00002000", bp_valid_out, bp_pc_out);
    end
    // Clear must not drop a commit presented alongside it.
    step(1, 1, 32'h2000, 1, 0, '0, 1);
    do_query(32'h2000);
    n_checks++;
    if (bp_taken_out !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_keeps_commit: got taken=%b, want 1", bp_taken_out);
    end
    do_commit(32'h2000, 0);
    idle();
  endtask

  task automatic test_reset_midop();
    // Capture a taken commit together with a query so outputs are non-zero.
    step(1, 1, 32'h1000, 1, 1, 32'h1000, 0);
    #3;
    rst_in = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bp_valid_out !== 1'b0 || bp_taken_out !== 1'b0 || bp_pc_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got valid=%b taken=%b pc=%h, want 0/0/0",
               bp_valid_out, bp_taken_out, bp_pc_out);
    end
    #1;
    rst_in = 1'b1;
    do_query(32'h1000);
    n_checks++;
    if (bp_valid_out !== 1'b1 || bp_taken_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_pending_lost: got valid=%b taken=%b, want 1/0",
               bp_valid_out, bp_taken_out);
    end
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] pc;
      pc = 32'h4000 + ADDR_W'($urandom_range(0, ENTRIES - 1) << 2);
      do_query(pc);
      n_checks++;
      if (bp_taken_out !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset_table_%0d: pc=%h got taken=%b, want 0", i, pc, bp_taken_out);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] cpc, qpc;
      bit rdy, ce, cb, qe, clr;
      cpc = 32'h1000 + ADDR_W'($urandom_range(0, 3) << 2) + ADDR_W'($urandom_range(0, 1) << 10)
            + ADDR_W'($urandom_range(0, 3));
      qpc = 32'h1000 + ADDR_W'($urandom_range(0, 3) << 2) + ADDR_W'($urandom_range(0, 1) << 10)
            + ADDR_W'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 7) != 0);
      ce  = $urandom_range(0, 1);
      cb  = $urandom_range(0, 1);
      qe  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step(rdy, ce, cpc, cb, qe, qpc, clr);
      n_checks++;
      if (bp_valid_out !== exp_valid || bp_taken_out !== exp_taken || bp_pc_out !== exp_pc) begin
        n_fail++;
        $display("FAIL random_%0d: got valid=%b taken=%b pc=%h, want %b/%b/%h",
                 n, bp_valid_out, bp_taken_out, bp_pc_out, exp_valid, exp_taken, exp_pc);
      end
    end
  endtask

  initial begin
    rst_in          = 1'b0;
    rdy_in          = 1'b1;
    commit_en_in    = 1'b0;
    commit_pc_in    = '0;
    commit_bpres_in = 1'b0;
    query_en_in     = 1'b0;
    query_pc_in     = '0;
    clear_in        = 1'b0;
    model_reset();
    test_reset();
    test_training();
    test_forwarding();
    test_aliasing();
    test_hold();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
